// File: rtl/eer_rl_pkg.sv
// Shared definitions for the heartbeat packet transmitter.
// Holds the packet length, the word-index constants that name each packet word,
// the default heartbeat type code and the transmitter FSM state encoding.
package eer_rl_pkg;

  localparam int PKT_LEN = 6;

  localparam logic [2:0] W_TYPE   = 3'd0;
  localparam logic [2:0] W_ID     = 3'd1;
  localparam logic [2:0] W_HOPS   = 3'd2;
  localparam logic [2:0] W_Q      = 3'd3;
  localparam logic [2:0] W_ENERGY = 3'd4;
  localparam logic [2:0] W_CSUM   = 3'(PKT_LEN - 1);

  localparam logic [3:0] HB_TYPE_DEF = 4'h1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hb_packet_tx.sv
// Heartbeat packet transmitter.
// On a single-cycle en_HBT request in IDLE, snapshots the node's payload and
// streams a 6-word packet over a valid/ready interface:
//   W0 = {role, low_E, 10'b0, HB_TYPE}, W1 = myNodeID, W2 = hopsFromSink,
//   W3 = myQValue, W4 = energy, W5 = XOR of W0..W4.
// Ports:
//   clk, nrst        : clock, synchronous active-low reset
//   en_HBT           : request to send one packet (ignored unless idle)
//   myNodeID, hopsFromSink, myQValue, energy, role, low_E : payload inputs
//   tx_ready         : downstream accepts the current word
//   tx_data/valid/last : outgoing word stream
//   busy             : packet words are being presented
//   done             : one-cycle pulse after the last word is accepted
module hb_packet_tx
  import eer_rl_pkg::*;
#(
  parameter logic [3:0] HB_TYPE = HB_TYPE_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en_HBT,
  input  logic [15:0] myNodeID,
  input  logic [15:0] hopsFromSink,
  input  logic [15:0] myQValue,
  input  logic [15:0] energy,
  input  logic        role,
  input  logic        low_E,
  input  logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        latch;

  logic [15:0] w0_q, id_q, hops_q, qv_q, energy_q, csum_q;
  logic [15:0] w0_new;

  assign w0_new = {role, low_E, 10'b0, HB_TYPE};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      w0_q     <= '0;
      id_q     <= '0;
      hops_q   <= '0;
      qv_q     <= '0;
      energy_q <= '0;
      csum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (latch) begin
        w0_q     <= w0_new;
        id_q     <= myNodeID;
        hops_q   <= hopsFromSink;
        qv_q     <= myQValue;
        energy_q <= energy;
        // Checksum formed from exactly the values being captured, so it
        // always matches the words that will be sent.
        csum_q   <= w0_new ^ myNodeID ^ hopsFromSink ^ myQValue ^ energy;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_HBT) begin
          state_d = ST_SEND;
          idx_d   = W_TYPE;
          latch   = 1'b1;
        end
      end
      ST_SEND: begin
        // Indices 6 and 7 cannot be reached; recover to IDLE if ever seen.
        if (idx_q > W_CSUM) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (tx_ready) begin
          if (idx_q == W_CSUM) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    busy     = 1'b0;
    done     = (state_q == ST_DONE);
    if (state_q == ST_SEND && idx_q <= W_CSUM) begin
      tx_valid = 1'b1;
      busy     = 1'b1;
      tx_last  = (idx_q == W_CSUM);
      case (idx_q)
        W_TYPE:   tx_data = w0_q;
        W_ID:     tx_data = id_q;
        W_HOPS:   tx_data = hops_q;
        W_Q:      tx_data = qv_q;
        W_ENERGY: tx_data = energy_q;
        W_CSUM:   tx_data = csum_q;
        default:  tx_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hb_packet_tx.sv
// Directed self-checking bench for hb_packet_tx.
module tb_hb_packet_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en_HBT;
  logic [15:0] myNodeID, hopsFromSink, myQValue, energy;
  logic        role, low_E, tx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_last, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hb_packet_tx #(.HB_TYPE(4'h1)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en_HBT       (en_HBT),
    .myNodeID     (myNodeID),
    .hopsFromSink (hopsFromSink),
    .myQValue     (myQValue),
    .energy       (energy),
    .role         (role),
    .low_E        (low_E),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 16'(tx_valid), 16'd0);
    check({tag, ".busy"},  16'(busy),     16'd0);
    check({tag, ".last"},  16'(tx_last),  16'd0);
    check({tag, ".data"},  tx_data,       16'd0);
  endtask

  task automatic start_pkt();
    en_HBT = 1'b1;
    tick();
    en_HBT = 1'b0;
  endtask

  // Checks one presented word, then advances with tx_ready=1.
  task automatic check_word(input string tag, input logic [15:0] exp, input logic is_last);
    check({tag, ".data"},  tx_data,        exp);
    check({tag, ".valid"}, 16'(tx_valid),  16'd1);
    check({tag, ".busy"},  16'(busy),      16'd1);
    check({tag, ".last"},  16'(tx_last),   16'(is_last));
    tick();
  endtask

  task automatic check_done(input string tag);
    check({tag, ".done"},  16'(done),     16'd1);
    check({tag, ".valid"}, 16'(tx_valid), 16'd0);
    check({tag, ".busy"},  16'(busy),     16'd0);
  endtask

  task automatic full_packet(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3,
                             input logic [15:0] e4, input logic [15:0] e5);
    check_word({tag, ".w0"}, e0, 1'b0);
    check_word({tag, ".w1"}, e1, 1'b0);
    check_word({tag, ".w2"}, e2, 1'b0);
    check_word({tag, ".w3"}, e3, 1'b0);
    check_word({tag, ".w4"}, e4, 1'b0);
    check_word({tag, ".w5"}, e5, 1'b1);
    check_done(tag);
    tick();
    check({tag, ".done_off"}, 16'(done), 16'd0);
    check_idle({tag, ".post"});
  endtask

  task automatic set_payload_a();
    role = 1'b1; low_E = 1'b0;
    myNodeID = 16'h1234; hopsFromSink = 16'h0003;
    myQValue = 16'h0100; energy = 16'h8000;
  endtask

  initial begin
    nrst = 1'b0; en_HBT = 1'b0; tx_ready = 1'b1;
    set_payload_a();
    tick();
    tick();
    check_idle("reset");
    check("reset.done", 16'(done), 16'd0);
    nrst = 1'b1;
    tick();

    // Basic packet streamed back to back.
    start_pkt();
    full_packet("basic", 16'h8001, 16'h1234, 16'h0003, 16'h0100, 16'h8000, 16'h1336);

    // Backpressure on W2.
    start_pkt();
    check_word("bp.w0", 16'h8001, 1'b0);
    check_word("bp.w1", 16'h1234, 1'b0);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp.hold.data", tx_data, 16'h0003);
      check("bp.hold.busy", 16'(busy), 16'd1);
      check("bp.hold.valid", 16'(tx_valid), 16'd1);
      check("bp.hold.last", 16'(tx_last), 16'd0);
      tick();
    end
    tx_ready = 1'b1;
    check_word("bp.w2", 16'h0003, 1'b0);
    check_word("bp.w3", 16'h0100, 1'b0);
    check_word("bp.w4", 16'h8000, 1'b0);
    check_word("bp.w5", 16'h1336, 1'b1);
    check_done("bp");
    tick();

    // Input changes and a stray request mid-packet.
    start_pkt();
    check_word("chg.w0", 16'h8001, 1'b0);
    check_word("chg.w1", 16'h1234, 1'b0);
    check_word("chg.w2", 16'h0003, 1'b0);
    role = 1'b0; low_E = 1'b1;
    myNodeID = 16'hFFFF; hopsFromSink = 16'h0009;
    myQValue = 16'h5555; energy = 16'h0001;
    en_HBT = 1'b1;
    check_word("chg.w3", 16'h0100, 1'b0);
    en_HBT = 1'b0;
    check_word("chg.w4", 16'h8000, 1'b0);
    check_word("chg.w5", 16'h1336, 1'b1);
    check_done("chg");
    tick();
    check_idle("chg.noq1");
    tick();
    check_idle("chg.noq2");
    set_payload_a();

    // Reset mid-packet at W4.
    start_pkt();
    check_word("rst.w0", 16'h8001, 1'b0);
    check_word("rst.w1", 16'h1234, 1'b0);
    check_word("rst.w2", 16'h0003, 1'b0);
    check_word("rst.w3", 16'h0100, 1'b0);
    check("rst.at_w4", tx_data, 16'h8000);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    check_idle("rst.abort");
    check("rst.abort.done", 16'(done), 16'd0);
    tick();
    check_idle("rst.noresume");
    start_pkt();
    full_packet("rst.new", 16'h8001, 16'h1234, 16'h0003, 16'h0100, 16'h8000, 16'h1336);

    // Low-energy flag in W0.
    role = 1'b0; low_E = 1'b1;
    start_pkt();
    full_packet("lowe", 16'h4001, 16'h1234, 16'h0003, 16'h0100, 16'h8000, 16'hD336);
    set_payload_a();

    // Request during the done cycle is dropped; one cycle later it starts.
    start_pkt();
    check_word("dn.w0", 16'h8001, 1'b0);
    check_word("dn.w1", 16'h1234, 1'b0);
    check_word("dn.w2", 16'h0003, 1'b0);
    check_word("dn.w3", 16'h0100, 1'b0);
    check_word("dn.w4", 16'h8000, 1'b0);
    check_word("dn.w5", 16'h1336, 1'b1);
    check_done("dn");
    start_pkt();
    check_idle("dn.ignored");
    start_pkt();
    full_packet("dn.next", 16'h8001, 16'h1234, 16'h0003, 16'h0100, 16'h8000, 16'h1336);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
